// File: rtl/mixcolumns_column_scheduler_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helper for the folded
// MixColumns column scheduler.
package mixcolumns_column_scheduler_pkg;

    localparam int AES_NB_BYTE   = 8;
    localparam int AES_N_ROWS    = 4;
    localparam int AES_N_COLUMNS = 4;
    localparam int AES_NB_COLUMN = AES_NB_BYTE * AES_N_ROWS;
    localparam int AES_NB_STATE  = AES_NB_COLUMN * AES_N_COLUMNS;

    localparam logic [AES_NB_BYTE-1:0] GF_REDUCE = 8'h1b;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } sched_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [AES_NB_BYTE-1:0] xtime(input logic [AES_NB_BYTE-1:0] b);
        return {b[AES_NB_BYTE-2:0], 1'b0} ^ (b[AES_NB_BYTE-1] ? GF_REDUCE : 8'h00);
    endfunction

endpackage

// File: rtl/mixcolumns_column_mult.sv
// Combinational MixColumns for one 32-bit column; row 0 in the MSB byte.
module mixcolumns_column_mult
    import mixcolumns_column_scheduler_pkg::*;
(
    input  logic [AES_NB_COLUMN-1:0] i_column,
    output logic [AES_NB_COLUMN-1:0] o_column
);

    logic [AES_NB_BYTE-1:0] a0, a1, a2, a3;
    logic [AES_NB_BYTE-1:0] x0, x1, x2, x3;

    always_comb begin
        a0 = i_column[31:24];
        a1 = i_column[23:16];
        a2 = i_column[15:8];
        a3 = i_column[7:0];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        // 3*a is formed as xtime(a) ^ a.
        o_column[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
        o_column[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
        o_column[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
        o_column[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
    end

endmodule

// File: rtl/mixcolumns_column_scheduler.sv
// Folded MixColumns: one AES state in, one column per clock through a shared
// column multiplier, result out; bypass passes the state through for the last round.
module mixcolumns_column_scheduler #(
    parameter  int NB_BYTE   = 8,
    parameter  int N_ROWS    = 4,
    parameter  int N_COLUMNS = 4,
    localparam int NB_STATE  = NB_BYTE * N_ROWS * N_COLUMNS
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [NB_STATE-1:0] i_state,
    input  logic                i_bypass,
    output logic                o_ready,
    output logic                o_valid,
    output logic [NB_STATE-1:0] o_state,
    input  logic                i_ready
);
    import mixcolumns_column_scheduler_pkg::*;

    if (NB_BYTE != AES_NB_BYTE || N_ROWS != AES_N_ROWS || N_COLUMNS != AES_N_COLUMNS)
    begin : gen_param_check
        $error("mixcolumns_column_scheduler: only NB_BYTE=8, N_ROWS=4, N_COLUMNS=4 supported");
    end

    sched_state_e state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [NB_STATE-1:0] src_q, src_d;
    logic [NB_STATE-1:0] res_q, res_d;

    logic                     accept;
    logic                     run_en;
    logic [AES_NB_COLUMN-1:0] src_col;
    logic [AES_NB_COLUMN-1:0] mix_col;

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    state_d = i_bypass ? StDone : StRun;
                end
            end
            StRun: begin
                if (cnt_q == 2'(N_COLUMNS - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Handoff and a fresh accept may share the same edge.
                if (i_ready) begin
                    if (i_valid) begin
                        state_d = i_bypass ? StDone : StRun;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; o_ready is the only path combinational from an input.
    always_comb begin
        o_ready = (state_q == StIdle) || ((state_q == StDone) && i_ready);
        o_valid = (state_q == StDone);
        run_en  = (state_q == StRun);
        accept  = o_ready && i_valid;
    end

    always_comb begin
        src_col = '0;
        for (int c = 0; c < AES_N_COLUMNS; c++) begin
            if (cnt_q == 2'(c)) begin
                src_col = src_q[(AES_N_COLUMNS - 1 - c) * AES_NB_COLUMN +: AES_NB_COLUMN];
            end
        end
    end

    mixcolumns_column_mult u_column_mult (
        .i_column (src_col),
        .o_column (mix_col)
    );

    always_comb begin
        src_d = src_q;
        res_d = res_q;
        cnt_d = cnt_q;
        if (accept) begin
            src_d = i_state;
            cnt_d = 2'd0;
            if (i_bypass) begin
                res_d = i_state;
            end
        end else if (run_en) begin
            for (int c = 0; c < AES_N_COLUMNS; c++) begin
                if (cnt_q == 2'(c)) begin
                    res_d[(AES_N_COLUMNS - 1 - c) * AES_NB_COLUMN +: AES_NB_COLUMN] = mix_col;
                end
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            src_q <= '0;
            res_q <= '0;
            cnt_q <= 2'd0;
        end else begin
            src_q <= src_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_state = res_q;

endmodule

// File: tb/tb_mixcolumns_column_scheduler.sv
// Scoreboard bench for mixcolumns_column_scheduler: stimulus queues expected
// results, a negedge monitor checks data, latency and handshake behaviour.
module tb_mixcolumns_column_scheduler;

    localparam logic [127:0] VEC_A     = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] EXP_A     = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] VEC_B     = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] EXP_B     = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] VEC_BYP   = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] VEC_ONES  = 128'h01010101_01010101_01010101_01010101;
    // Offset of the edge that raises o_valid, counted from the accept edge E0.
    localparam int LAT_NORMAL = 4;
    localparam int LAT_BYPASS = 0;

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_valid;
    logic [127:0] i_state;
    logic         i_bypass;
    logic         o_ready;
    logic         o_valid;
    logic [127:0] o_state;
    logic         i_ready;

    typedef struct {
        logic [127:0] st;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    mixcolumns_column_scheduler dut (
        .i_clock (clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_state (i_state),
        .i_bypass(i_bypass),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_state (o_state),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t cur;
        bit   have_cur = 0;
        bit   prev_valid = 0;
        bit   prev_hs = 0;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                acc_q.delete();
                have_cur   = 0;
                prev_valid = 0;
                prev_hs    = 0;
            end else begin
                if (i_valid && o_ready) acc_q.push_back(cyc + 1);
                if (o_valid && (!prev_valid || prev_hs)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", {127'd0, o_valid}, 128'd0);
                        have_cur = 0;
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1;
                        if (acc_q.size() == 0) begin
                            check("missing_accept", 128'd0, 128'd1);
                        end else begin
                            check("latency", 128'(cyc - acc_q.pop_front()), 128'(cur.lat));
                        end
                    end
                end
                if (o_valid && have_cur) begin
                    check("o_state", o_state, cur.st);
                    check("o_ready_in_done", {127'd0, o_ready}, {127'd0, i_ready});
                end
                if (o_valid && i_ready) have_cur = 0;
                prev_valid = o_valid;
                prev_hs    = o_valid && i_ready;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [127:0] st, input logic bp, input bit push,
                        input logic [127:0] exp_st, output int acc_edge);
        bit got = 0;
        if (push) exp_q.push_back('{st: exp_st, lat: (bp ? LAT_BYPASS : LAT_NORMAL)});
        i_valid  = 1'b1;
        i_state  = st;
        i_bypass = bp;
        acc_edge = -1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (o_ready) got = 1;
            @(posedge clk);
            #1;
        end
        if (got) acc_edge = cyc;
        else check("accept_timeout", 128'd0, 128'd1);
        i_valid  = 1'b0;
        i_bypass = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_pending", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e0, e_prev;
        i_reset  = 1'b1;
        i_valid  = 1'b0;
        i_state  = '0;
        i_bypass = 1'b0;
        i_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        check("reset_o_valid", {127'd0, o_valid}, 128'd0);
        check("reset_o_state", o_state, 128'd0);
        check("reset_o_ready", {127'd0, o_ready}, 128'd1);
        @(posedge clk);
        #1;

        // Normal path.
        send(VEC_A, 1'b0, 1, EXP_A, e0);
        drain();

        // Backpressure: result must hold while i_ready is low.
        i_ready = 1'b0;
        send(VEC_B, 1'b0, 1, EXP_B, e0);
        for (int k = 0; k < 20 && !o_valid; k++) @(negedge clk);
        check("bp_valid_seen", {127'd0, o_valid}, 128'd1);
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b1;
        drain();

        // Bypass.
        send(VEC_BYP, 1'b1, 1, VEC_BYP, e0);
        drain();

        // Back-to-back, alternating vectors: one accept per 5 clocks.
        send(VEC_A, 1'b0, 1, EXP_A, e_prev);
        for (int n = 1; n < 4; n++) begin
            if (n % 2 == 1) send(VEC_B, 1'b0, 1, EXP_B, e0);
            else send(VEC_A, 1'b0, 1, EXP_A, e0);
            check("b2b_period", 128'(e0 - e_prev), 128'd5);
            e_prev = e0;
        end
        drain();

        // Reset mid-RUN: reset sampled at E2, nothing emitted.
        send(VEC_A, 1'b0, 0, EXP_A, e0);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        check("rst_run_o_valid", {127'd0, o_valid}, 128'd0);
        check("rst_run_o_state", o_state, 128'd0);
        check("rst_run_o_ready", {127'd0, o_ready}, 128'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_run_quiet", {127'd0, o_valid}, 128'd0);
        end
        @(posedge clk);
        #1;
        send(VEC_ONES, 1'b0, 1, VEC_ONES, e0);
        drain();

        // i_valid during RUN is ignored.
        send(VEC_A, 1'b0, 1, EXP_A, e0);
        i_valid = 1'b1;
        i_state = VEC_B;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("run_o_ready", {127'd0, o_ready}, 128'd0);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        drain();
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
